// File: rtl/jtdd_pcm_seq.sv
// jtdd_pcm_seq: multi-channel ADPCM nibble sequencer sharing one PCM ROM port.
// Round-robin arbitration, per-channel loop/bank/rate and end-of-sample interrupts.
module jtdd_pcm_seq #(
    parameter int CH = 2,
    parameter int CW = 14,
    parameter int BW = 3,
    parameter int AW = BW + CW - 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr,
    input  logic [1:0]      ch_sel,
    input  logic [1:0]      reg_addr,
    input  logic [7:0]      din,
    output logic [7:0]      dout,
    output logic            irq_n,
    input  logic [CH-1:0]   vclk,
    output logic [4*CH-1:0] pcm_din,
    output logic [CH-1:0]   pcm_rst,
    output logic [2*CH-1:0] pcm_sel,
    output logic [AW-1:0]   rom_addr,
    output logic            rom_cs,
    input  logic [7:0]      rom_data,
    input  logic            rom_ok
);
    typedef enum logic [1:0] {IDLE, FETCH, PLAY} st_t;

    st_t           st_q   [CH];
    st_t           st_d   [CH];
    logic [CW-1:0] cnt_q  [CH];
    logic [CW-1:0] cnt_d  [CH];
    logic [7:0]    smp_q  [CH];
    logic [7:0]    smp_d  [CH];
    logic [BW-1:0] bank_q [CH];
    logic [BW-1:0] bank_d [CH];
    logic [1:0]    sel_q  [CH];
    logic [1:0]    sel_d  [CH];
    logic [CH-1:0] loop_q, loop_d, irq_q, irq_d;
    logic          rom_cs_q, rom_cs_d, stable_q;
    logic [AW-1:0] addr_q, addr_d, pick_addr;
    logic [1:0]    gnt_q, gnt_d, ptr_q, ptr_d, pick;
    logic [7:0]    dout_q;
    logic          irq_n_q;
    logic [CH-1:0] start, stop, req, busy;
    logic          wr_ok, accept, abandon, found;

    always_comb begin
        wr_ok   = wr && int'(ch_sel) < CH;
        start   = '0;
        stop    = '0;
        req     = '0;
        busy    = '0;
        abandon = 1'b0;
        for (int n = 0; n < CH; n++) begin
            start[n] = wr_ok && reg_addr == 2'd1 && int'(ch_sel) == n;
            stop[n]  = wr_ok && reg_addr == 2'd2 && int'(ch_sel) == n;
            busy[n]  = st_q[n] != IDLE;
            req[n]   = st_q[n] == FETCH && !start[n] && !stop[n];
            abandon  = abandon || (rom_cs_q && int'(gnt_q) == n && (start[n] || stop[n]));
        end
        accept = rom_cs_q && stable_q && rom_ok && !abandon;
    end

    // Scan downwards so the requester closest to the pointer is the last one written.
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        pick_addr = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            if (req[(int'(ptr_q) + k) % CH]) begin
                found = 1'b1;
                pick  = 2'((int'(ptr_q) + k) % CH);
            end
        end
        for (int n = 0; n < CH; n++)
            if (int'(pick) == n) pick_addr = {bank_q[n], cnt_q[n][CW-1:1]};
        rom_cs_d = rom_cs_q ? !(accept || abandon) : found;
        addr_d   = (!rom_cs_q && found) ? pick_addr : addr_q;
        gnt_d    = (!rom_cs_q && found) ? pick : gnt_q;
        ptr_d    = accept ? 2'((int'(gnt_q) + 1) % CH) : ptr_q;
    end

    always_comb begin
        loop_d = loop_q;
        irq_d  = irq_q;
        for (int n = 0; n < CH; n++) begin
            st_d[n]   = st_q[n];
            cnt_d[n]  = cnt_q[n];
            smp_d[n]  = smp_q[n];
            bank_d[n] = bank_q[n];
            sel_d[n]  = sel_q[n];
            if (wr_ok && reg_addr == 2'd3 && din[n]) irq_d[n] = 1'b0;
            if (wr_ok && reg_addr == 2'd0 && int'(ch_sel) == n) begin
                loop_d[n] = din[7];
                sel_d[n]  = din[6:5];
                bank_d[n] = din[BW-1:0];
            end
            if (start[n]) begin
                cnt_d[n] = '0;
                st_d[n]  = FETCH;
            end else if (stop[n]) begin
                st_d[n] = IDLE;
            end else if (accept && int'(gnt_q) == n) begin
                smp_d[n] = rom_data;
                st_d[n]  = PLAY;
            end else if (st_q[n] == PLAY && vclk[n]) begin
                cnt_d[n] = cnt_q[n] + CW'(1);
                st_d[n]  = &cnt_q[n] ? (loop_q[n] ? FETCH : IDLE) : (cnt_q[n][0] ? FETCH : PLAY);
                if (&cnt_q[n]) irq_d[n] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < CH; n++) begin
                st_q[n]   <= IDLE;
                cnt_q[n]  <= '0;
                smp_q[n]  <= '0;
                bank_q[n] <= '0;
                sel_q[n]  <= '0;
            end
            loop_q   <= '0;
            irq_q    <= '0;
            rom_cs_q <= 1'b0;
            stable_q <= 1'b0;
            addr_q   <= '0;
            gnt_q    <= '0;
            ptr_q    <= '0;
            dout_q   <= '0;
            irq_n_q  <= 1'b1;
        end else begin
            for (int n = 0; n < CH; n++) begin
                st_q[n]   <= st_d[n];
                cnt_q[n]  <= cnt_d[n];
                smp_q[n]  <= smp_d[n];
                bank_q[n] <= bank_d[n];
                sel_q[n]  <= sel_d[n];
            end
            loop_q   <= loop_d;
            irq_q    <= irq_d;
            rom_cs_q <= rom_cs_d;
            stable_q <= rom_cs_q && rom_cs_d;
            addr_q   <= addr_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            dout_q   <= {4'(busy), 4'(irq_q)};
            irq_n_q  <= ~|irq_q;
        end
    end

    always_comb begin
        pcm_din = '0;
        pcm_rst = '0;
        pcm_sel = '0;
        for (int n = 0; n < CH; n++) begin
            pcm_din[4*n +: 4] = cnt_q[n][0] ? smp_q[n][7:4] : smp_q[n][3:0];
            pcm_rst[n]        = st_q[n] == IDLE;
            pcm_sel[2*n +: 2] = sel_q[n];
        end
    end

    assign dout     = dout_q;
    assign irq_n    = irq_n_q;
    assign rom_cs   = rom_cs_q;
    assign rom_addr = addr_q;
endmodule

// File: doc/jtdd_pcm_seq.md
# jtdd_pcm_seq

Parametrised multi-channel ADPCM sample sequencer. It replaces the single-channel start/stop/counter/NMI logic that sits between a sound CPU and its MSM5205-style decoders (jt5205). It supports CH channels, configurable length and bank widths, and loop mode. It arbitrates one shared PCM ROM port, feeds one nibble stream per decoder, and raises an end-of-sample interrupt per channel.

## Interface
Parameters:
- CH, 2: channel count, 1..4.
- CW, 14: nibble counter width; sample length is 2^CW nibbles.
- BW, 3: bank bits per channel, 1..5.
- AW, BW+CW-1: ROM address width (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- wr  in  1  CPU write strobe, one clk per access.
- ch_sel  in  2  target channel; writes with ch_sel ≥ CH are ignored.
- reg_addr  in  2  register: 0 ctrl, 1 start, 2 stop, 3 irq ack.
- din  in  8  CPU write data.
- dout  out  8  status: {busy[3:0], irq_st[3:0]}; unused bits read 0.
- irq_n  out  1  low while any irq_st bit is set.
- vclk  in  CH  per-channel nibble-consumed pulse from each decoder (its vclk_o), one clk wide.
- pcm_din  out  4*CH  current nibble; channel n uses bits [4n+3:4n].
- pcm_rst  out  CH  decoder reset; high when the channel is idle.
- pcm_sel  out  2*CH  decoder rate select from ctrl.
- rom_addr  out  AW  {bank, cnt[CW-1:1]} of the granted channel.
- rom_cs  out  1  ROM request.
- rom_data  in  8  ROM byte.
- rom_ok  in  1  ROM data valid.

## Operation
- Per-channel registers: loop (ctrl din[7]), sel (din[6:5]), bank (din[BW-1:0]), cnt[CW-1:0], byte[7:0], state.
- States: IDLE, FETCH, PLAY.
- Nibble order: pcm_din = cnt[0] ? byte[7:4] : byte[3:0], so the low nibble plays first.
- Start write: cnt←0, state←FETCH, pcm_rst←0. This applies in any state, so a start while playing restarts the sample.
- Stop write: state←IDLE, pcm_rst←1. No irq. Start and stop to the same channel in the same cycle: start wins.
- FETCH: the channel is a requester. When its byte is accepted: byte←rom_data, state←PLAY.
- PLAY, vclk pulse, cnt[0]=0: cnt←cnt+1. The channel stays in PLAY and the high nibble is presented.
- PLAY, vclk pulse, cnt[0]=1 and cnt not all ones: cnt←cnt+1, state←FETCH.
- PLAY, vclk pulse, cnt all ones (end of sample): irq_st[n]←1.
  - loop=1: cnt wraps to 0, state←FETCH.
  - loop=0: state←IDLE, pcm_rst←1.
- vclk during FETCH or IDLE is dropped; cnt does not advance.
- Ctrl writes take effect immediately on pcm_sel. A bank change affects the next fetch only.
- Irq ack write clears irq_st bits where din[CH-1:0]=1. If a set and a clear hit the same bit in the same cycle, set wins.
- busy[n] = state≠IDLE.

## Arbitration and ROM handshake
- Only one request is outstanding at a time. Channels are served round-robin; the pointer moves to grant+1 after each accepted byte.
- On grant, rom_addr is driven from that channel and rom_cs goes high. Both stay stable until acceptance.
- A byte is accepted on the first cycle where rom_cs=1, rom_ok=1, and the address has been stable for at least one prior cycle. rom_ok in the first cycle of a request is ignored.
- rom_cs drops for one cycle after each acceptance, then re-arbitrates.
- If the granted channel receives start or stop while its request is pending, the request is abandoned. rom_cs drops, and a later start re-requests.

## Timing
- Reset values:
  - All channels IDLE, cnt=0, byte=0, loop=0, sel=0, bank=0.
  - pcm_rst all 1, pcm_din 0, irq_st 0, irq_n 1.
  - rom_cs 0, rom_addr 0, dout 0, arbitration pointer at channel 0.
- Register writes take effect on the clk edge where wr=1.
- dout and irq_n are registered: one clk after the state change.
- pcm_din updates on the clk edge after a vclk or byte acceptance.
- Fetch latency from FETCH entry: minimum 3 clk (arbitrate, address-stable cycle, accept), plus waiting for other channels.

## Test plan
- Reset mid-fetch (rst while rom_cs=1) -> every output returns to its reset value next clk. After release, no request until a start.
- CH=2, ch0 bank=5, start, rom_ok after 2 clk, data 8'hA3 -> rom_addr=5<<13, then pcm_din[3:0]=3. After 1 vclk -> A. After 2nd vclk -> rom_addr=(5<<13)+1.
- CW=4, loop=0, 16 vclk -> irq_st=01, irq_n=0, pcm_rst[0]=1. Ack din=1 -> irq_n=1 one clk later.
- CW=4, loop=1 -> after 16 vclk, irq set, cnt=0, rom_addr back to bank base, busy stays 1.
- Both channels in FETCH together -> grants alternate ch0, ch1, ch0. rom_cs low for one clk between grants.
- Start and stop to ch1 in the same cycle -> channel starts. Irq set and ack on the same cycle -> bit stays set.
